// File: rtl/enc_seg_display.sv
// rtl/enc_seg_display.sv - encoder position byte to BCD with multiplexed 7-segment drive
//
// Purpose:
//   Converts the 8-bit encoder position to 3-digit BCD using a sequential
//   double-dabble FSM, then scans the result onto a 4-digit common-anode
//   display with leading-zero blanking.
//
// Ports:
//   clk    in   1   system clock
//   reset  in   1   asynchronous active-high reset
//   value  in   8   unsigned position 0..255
//   an     out  4   digit anodes, active-low, an[0] = rightmost digit
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point, active-low, always off
//   bcd    out  12  latched BCD {hundreds,tens,units}
//   busy   out  1   high while a conversion is in progress
module enc_seg_display #(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [SCAN_BITS-1:0] SCAN_ONE = 1;

  state_t               state, state_nx;
  logic [7:0]           shown_val, shown_nx;
  logic [19:0]          sr, sr_nx;
  logic [2:0]           step, step_nx;
  logic [11:0]          bcd_nx;
  logic                 busy_nx;
  logic [SCAN_BITS-1:0] scan;
  logic [1:0]           d;
  logic [3:0]           an_nx;
  logic [6:0]           seg_nx;

  // Add-3 correction on every BCD nibble >= 5, then shift left by one.
  // sr layout: [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shown_val <= 8'd0;
      sr        <= 20'd0;
      step      <= 3'd0;
      bcd       <= 12'h000;
      busy      <= 1'b0;
      scan      <= '0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
    end else begin
      state     <= state_nx;
      shown_val <= shown_nx;
      sr        <= sr_nx;
      step      <= step_nx;
      bcd       <= bcd_nx;
      busy      <= busy_nx;
      scan      <= scan + SCAN_ONE;
      an        <= an_nx;
      seg       <= seg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shown_nx = shown_val;
    sr_nx    = sr;
    step_nx  = step;
    bcd_nx   = bcd;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        if (value != shown_val) begin
          sr_nx    = {12'h000, value};
          shown_nx = value;
          step_nx  = 3'd0;
          busy_nx  = 1'b1;
          state_nx = CONV;
        end
      end
      CONV: begin
        sr_nx   = dabble_step(sr);
        step_nx = step + 3'd1;
        if (step == 3'd7) state_nx = LOAD;
      end
      LOAD: begin
        bcd_nx   = sr[19:8];
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Display reads only the latched bcd; the slot picked by the top two
  // scan bits is registered, so an/seg trail a digit change by one clock.
  assign d = scan[SCAN_BITS-1 -: 2];

  always_comb begin
    an_nx  = 4'b1111;
    seg_nx = 7'b1111111;
    case (d)
      2'd0: begin
        an_nx  = 4'b1110;
        seg_nx = seg_code(bcd[3:0]);
      end
      2'd1: begin
        if (bcd[11:8] != 4'd0 || bcd[7:4] != 4'd0) begin
          an_nx  = 4'b1101;
          seg_nx = seg_code(bcd[7:4]);
        end
      end
      2'd2: begin
        if (bcd[11:8] != 4'd0) begin
          an_nx  = 4'b1011;
          seg_nx = seg_code(bcd[11:8]);
        end
      end
      default: begin
        an_nx  = 4'b1111;
        seg_nx = 7'b1111111;
      end
    endcase
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_enc_seg_display.sv
// tb/tb_enc_seg_display.sv - self-checking bench for enc_seg_display
module tb_enc_seg_display;

  logic        clk;
  logic        reset;
  logic [7:0]  value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] bcd;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  logic        prev_busy;
  logic [11:0] prev_bcd;

  enc_seg_display #(.SCAN_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .bcd   (bcd),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic [6:0] exp_seg(input int n);
    logic [6:0] c;
    case (n)
      0: c = 7'b1000000;
      1: c = 7'b1111001;
      2: c = 7'b0100100;
      3: c = 7'b0110000;
      4: c = 7'b0011001;
      5: c = 7'b0010010;
      6: c = 7'b0000010;
      7: c = 7'b1111000;
      8: c = 7'b0000000;
      9: c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // Scoreboard: every completed conversion (busy falling) must match the
  // oldest pushed expectation; any other change of bcd outside reset is wrong.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_bcd  = bcd;
    end else begin
      if (prev_busy && !busy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: bcd=%h produced with empty queue", bcd);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (bcd !== e) begin
            n_fail++;
            $display("FAIL sb_bcd: got %h expected %h", bcd, e);
          end
        end
      end else if (bcd !== prev_bcd) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_spurious: bcd changed %h -> %h without completion", prev_bcd, bcd);
      end
      prev_busy = busy;
      prev_bcd  = bcd;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    value = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, bcd, busy} !== {4'b1111, 7'b1111111, 1'b1, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: an=%b seg=%b dp=%b bcd=%h busy=%b", an, seg, dp, bcd, busy);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ea;
      logic [6:0] es;
      @(negedge clk);
      ea = (i < 4) ? 4'b1110 : 4'b1111;
      es = (i < 4) ? 7'b1000000 : 7'b1111111;
      n_cmp++;
      if (an !== ea || seg !== es || busy !== 1'b0 || bcd !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_scan[%0d]: an=%b seg=%b busy=%b bcd=%h expected an=%b seg=%b", i, an, seg, busy, bcd, ea, es);
      end
    end
  endtask

  // Single conversion with exact busy/bcd latency check.
  task automatic test_convert(input int v);
    logic [11:0] old_bcd;
    old_bcd = bcd;
    @(negedge clk);
    value = 8'(v);
    exp_q.push_back(to_bcd(v));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (i < 9)) begin
        n_fail++;
        $display("FAIL conv%0d_busy[%0d]: got %b expected %b", v, i, busy, (i < 9));
      end
      n_cmp++;
      if (bcd !== ((i < 9) ? old_bcd : to_bcd(v))) begin
        n_fail++;
        $display("FAIL conv%0d_bcd[%0d]: got %h expected %h", v, i, bcd, (i < 9) ? old_bcd : to_bcd(v));
      end
    end
  endtask

  // One full scan period: every lit slot shows the right digit, blanked
  // slots never light, each lit digit is on for exactly four clocks.
  task automatic test_display(input int v);
    int h, t, u, cu, ct, ch, cbad;
    logic lit_t, lit_h;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    lit_h = (h != 0);
    lit_t = (h != 0) || (t != 0);
    cu = 0; ct = 0; ch = 0; cbad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++;
      case (an)
        4'b1111: if (seg !== 7'b1111111) begin
          n_fail++;
          $display("FAIL disp%0d_dark: seg=%b expected 1111111", v, seg);
        end
        4'b1110: begin
          cu++;
          if (seg !== exp_seg(u)) begin
            n_fail++;
            $display("FAIL disp%0d_units: seg=%b expected %b", v, seg, exp_seg(u));
          end
        end
        4'b1101: begin
          ct++;
          if (seg !== exp_seg(t)) begin
            n_fail++;
            $display("FAIL disp%0d_tens: seg=%b expected %b", v, seg, exp_seg(t));
          end
        end
        4'b1011: begin
          ch++;
          if (seg !== exp_seg(h)) begin
            n_fail++;
            $display("FAIL disp%0d_hund: seg=%b expected %b", v, seg, exp_seg(h));
          end
        end
        default: begin
          cbad++;
          n_fail++;
          $display("FAIL disp%0d_an: an=%b is not a legal slot", v, an);
        end
      endcase
      if (dp !== 1'b1) begin
        n_fail++;
        $display("FAIL disp%0d_dp: dp=%b expected 1", v, dp);
      end
    end
    n_cmp++;
    if (cu != 4 || ct != (lit_t ? 4 : 0) || ch != (lit_h ? 4 : 0) || cbad != 0) begin
      n_fail++;
      $display("FAIL disp%0d_counts: u=%0d t=%0d h=%0d expected u=4 t=%0d h=%0d", v, cu, ct, ch, lit_t ? 4 : 0, lit_h ? 4 : 0);
    end
  endtask

  // 42 then 200 mid-conversion: 042 lands first, 200 follows on the next IDLE.
  task automatic test_back_to_back();
    logic [11:0] old_bcd;
    old_bcd = bcd;
    @(negedge clk);
    value = 8'd42;
    exp_q.push_back(to_bcd(42));
    for (int i = 0; i < 20; i++) begin
      logic        eb;
      logic [11:0] ed;
      @(negedge clk);
      if (i == 2) begin
        value = 8'd200;
        exp_q.push_back(to_bcd(200));
      end
      eb = (i <= 8) || (i >= 10 && i <= 18);
      ed = (i < 9) ? old_bcd : ((i < 19) ? to_bcd(42) : to_bcd(200));
      n_cmp++;
      if (busy !== eb || bcd !== ed) begin
        n_fail++;
        $display("FAIL b2b[%0d]: busy=%b bcd=%h expected busy=%b bcd=%h", i, busy, bcd, eb, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    value = 8'd99;
    exp_q.push_back(to_bcd(99));
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({an, seg, dp, bcd, busy} !== {4'b1111, 7'b1111111, 1'b1, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_vals: an=%b seg=%b dp=%b bcd=%h busy=%b", an, seg, dp, bcd, busy);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (i < 9) || bcd !== ((i < 9) ? 12'h000 : 12'h099)) begin
        n_fail++;
        $display("FAIL mid_reconv[%0d]: busy=%b bcd=%h expected busy=%b bcd=%h", i, busy, bcd, (i < 9), (i < 9) ? 12'h000 : 12'h099);
      end
    end
  endtask

  initial begin
    prev_busy = 1'b0;
    prev_bcd  = 12'h000;
    test_reset();
    test_convert(255);
    test_display(255);
    test_convert(7);
    test_display(7);
    test_convert(100);
    test_display(100);
    test_back_to_back();
    test_display(200);
    test_reset_mid();
    test_display(99);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0 || bcd !== 12'h099) begin
      n_fail++;
      $display("FAIL steady: queue=%0d busy=%b bcd=%h expected 0 0 099", exp_q.size(), busy, bcd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_seg_display.md
Name: enc_seg_display

Overview:
- Downstream consumer of the rotary-encoder position byte (8-bit count/4 output).
- Converts the unsigned byte to 3-digit BCD with a sequential double-dabble FSM.
- Drives the Basys2 4-digit multiplexed common-anode 7-segment display with leading-zero blanking.
- Sits between the encoder block and the board display pins.

Parameters:
- SCAN_BITS, 16, width of the free-running scan counter. Each digit is lit for 2^(SCAN_BITS-2) clocks. Use 4 in simulation.

Ports:
- clk  in  1  system clock (50 MHz on board)
- reset  in  1  asynchronous, active-high reset
- value  in  8  unsigned position from encoder, 0..255, synchronous to clk
- an  out  4  digit anodes, active-low; an[0] = rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low, constant 1 (off)
- bcd  out  12  latched BCD {hundreds,tens,units}, for observation
- busy  out  1  high while a conversion is in progress

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, bcd=12'h000, busy=0, scan counter=0, FSM=IDLE, shown_val=0.
- FSM states: IDLE, CONV, LOAD.
- IDLE:
  - When value != shown_val, latch value into the binary part of a 20-bit shift register and clear the BCD part.
  - Set shown_val<=value, step<=0, busy<=1, go to CONV.
  - Otherwise stay in IDLE.
- CONV:
  - One double-dabble step per clock: add 3 to each BCD nibble >=5, then shift the whole register left by 1.
  - step increments each cycle. After the 8th step (step==7), go to LOAD.
- LOAD: bcd<=BCD part of the shift register, busy<=0, go to IDLE.
- Latency: with value changed and sampled at edge k, bcd is valid after edge k+9. busy is high from edge k through edge k+9 (cleared at k+9).
- Change during conversion: value is ignored until IDLE. If value then differs from shown_val, a new conversion starts on the first IDLE cycle. bcd never shows a partial result.
- Steady input: no conversion runs; bcd holds.
- Scan counter:
  - SCAN_BITS-bit free-running up-counter that wraps from all-ones to 0.
  - digit select d = counter[SCAN_BITS-1:SCAN_BITS-2].
- Digit map: d=0 units, d=1 tens, d=2 hundreds, d=3 unused. For d=3, an stays 1111 and seg stays 1111111.
- Leading-zero blanking:
  - Hundreds is blanked when 0.
  - Tens is blanked when hundreds==0 and tens==0.
  - Units is never blanked.
  - A blanked slot drives an=1111 and seg=1111111.
- Registered outputs: an and seg update one clock after d changes. A lit slot drives exactly one an bit low, matching d.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Display source: reads bcd only, never the in-flight shift register.
- Reset mid-conversion: all state returns to reset values immediately. After release, a non-zero value triggers a fresh conversion from IDLE.

Test Plan:
1. Reset, value=0 held, SCAN_BITS=4 -> bcd=000, busy stays 0. Across one full 16-clock scan only an=1110 lights, with seg=1000000; all other slots an=1111.
2. value 0->255 at edge k -> busy=1 for edges k..k+8, bcd=12'h255 after edge k+9. Scan shows an=1110/seg=0010010, an=1101/seg=0010010, an=1011/seg=0100100.
3. value=7 -> bcd=007. Only the units slot is lit, seg=1111000; tens and hundreds slots show an=1111.
4. value=100 -> bcd=100. Hundreds shows seg=1111001, tens shows seg=1000000 (not blanked), units shows seg=1000000.
5. value=42, then 200 at edge k+3 mid-conversion -> bcd=042 at k+9. A second conversion starts at k+10 and gives bcd=200 at k+19. No other bcd value ever appears.
6. Assert reset at k+4 of a conversion of 99, then release -> all outputs at reset values immediately. On release with value=99 held, bcd=099 nine cycles after the first IDLE edge.
